// File: rtl/rank_order_decoder_if.sv
// AER event link between the spike encoder (master) and the rank-order decoder (slave).
// The sender drives address and strobe; the receiver returns back-pressure.
interface rank_order_decoder_if #(
    parameter int IMAGE_SIZE_BITS = 8
);
    logic [IMAGE_SIZE_BITS+1:0] AER_ADDR;
    logic                       AER_REQ;
    logic                       AER_BUSY;

    modport master (output AER_ADDR, output AER_REQ, input AER_BUSY);
    modport slave  (input AER_ADDR, input AER_REQ, output AER_BUSY);
endinterface

// File: rtl/rank_order_decoder.sv
// Rank-order spike decoder: detects the two-marker preamble, then records each pixel's
// arrival order as its rank, with busy back-pressure and sticky error flags.
module rank_order_decoder #(
    parameter int IMAGE_SIZE      = 256,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int BUSY_CYCLES     = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    rank_order_decoder_if.slave        aer,
    input  logic                       INFERENCE_DONE,
    output logic [IMAGE_SIZE_BITS-1:0] RANK [0:IMAGE_SIZE-1],
    output logic [IMAGE_SIZE-1:0]      RANK_VALID,
    output logic [IMAGE_SIZE_BITS:0]   EVENT_COUNT,
    output logic                       FRAME_DONE,
    output logic                       ERR_DUPLICATE,
    output logic                       ERR_RANGE,
    output logic                       ERR_OVERRUN
);
    localparam int                AW        = IMAGE_SIZE_BITS + 2;
    localparam int                CW        = IMAGE_SIZE_BITS + 1;
    localparam logic [AW-1:0]     MARKER    = {2'b01, {IMAGE_SIZE_BITS{1'b1}}};
    localparam logic [AW-1:0]     ADDR_LIM  = AW'(IMAGE_SIZE);
    localparam logic [CW-1:0]     FULL      = CW'(IMAGE_SIZE);
    localparam logic [3:0]        BUSY_LOAD = 4'(BUSY_CYCLES);

    typedef enum logic [1:0] {IDLE, SYNC1, RECEIVE, DONE} state_t;

    state_t                     state, next_state;
    logic [3:0]                 busy_cnt;
    logic                       accept, overrun, is_marker, in_range;
    logic [IMAGE_SIZE_BITS-1:0] idx;
    logic [CW-1:0]              count_next;
    logic                       do_clear, do_write, set_dup, set_range;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c >= FULL) ? FULL : c + CW'(1);
    endfunction

    assign aer.AER_BUSY = (busy_cnt != 4'd0);
    assign accept       = aer.AER_REQ && !aer.AER_BUSY;
    assign overrun      = aer.AER_REQ && aer.AER_BUSY;
    assign is_marker    = (aer.AER_ADDR == MARKER);
    // Range is decided on the full address before any table lookup.
    assign in_range     = (aer.AER_ADDR < ADDR_LIM);
    assign idx          = aer.AER_ADDR[IMAGE_SIZE_BITS-1:0];
    assign count_next   = sat_inc(EVENT_COUNT);
    assign FRAME_DONE   = (state == DONE);

    always_comb begin
        next_state = state;
        do_clear   = 1'b0;
        do_write   = 1'b0;
        set_dup    = 1'b0;
        set_range  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_marker) next_state = SYNC1;
            end
            SYNC1: begin
                if (accept) begin
                    if (is_marker) begin
                        next_state = RECEIVE;
                        do_clear   = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            RECEIVE: begin
                if (accept) begin
                    if (is_marker) begin
                        next_state = SYNC1;
                    end else if (!in_range) begin
                        set_range = 1'b1;
                    end else if (RANK_VALID[idx]) begin
                        set_dup = 1'b1;
                    end else begin
                        do_write = 1'b1;
                        if (count_next == FULL) next_state = DONE;
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // An abort wins over any event arriving in the same cycle.
        if (INFERENCE_DONE) begin
            next_state = IDLE;
            do_clear   = 1'b0;
            do_write   = 1'b0;
            set_dup    = 1'b0;
            set_range  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            busy_cnt      <= 4'd0;
            EVENT_COUNT   <= '0;
            RANK_VALID    <= '0;
            ERR_DUPLICATE <= 1'b0;
            ERR_RANGE     <= 1'b0;
            ERR_OVERRUN   <= 1'b0;
            for (int i = 0; i < IMAGE_SIZE; i++) RANK[i] <= '0;
        end else begin
            state <= next_state;
            if (accept) busy_cnt <= BUSY_LOAD;
            else if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;

            if (do_clear) begin
                EVENT_COUNT   <= '0;
                RANK_VALID    <= '0;
                ERR_DUPLICATE <= 1'b0;
                ERR_RANGE     <= 1'b0;
                ERR_OVERRUN   <= 1'b0;
            end else begin
                if (overrun)   ERR_OVERRUN   <= 1'b1;
                if (set_dup)   ERR_DUPLICATE <= 1'b1;
                if (set_range) ERR_RANGE     <= 1'b1;
            end

            // Rank is the pre-increment count, truncated to index width.
            if (do_write) begin
                RANK[idx]       <= EVENT_COUNT[IMAGE_SIZE_BITS-1:0];
                RANK_VALID[idx] <= 1'b1;
                EVENT_COUNT     <= count_next;
            end
        end
    end
endmodule

// File: doc/rank_order_decoder.md
# rank_order_decoder

Receiving end of the rank-order spike link that the image encoder drives. Accepts AER events (pixel index plus strobe), recognises the two-marker frame-start preamble, and records each pixel's arrival order as its rank. Exposes the rank table, the valid mask and frame-level status to the downstream classifier and to testbench scoreboards. Applies back-pressure through a busy flag that mirrors the AER input controller the encoder already waits on.

## Interface

- `IMAGE_SIZE`, 256: pixels per frame.
- `IMAGE_SIZE_BITS`, `$clog2(IMAGE_SIZE)`: pixel-index width.
- `BUSY_CYCLES`, 2: cycles `AER_BUSY` stays high after each accepted event; legal range 1–15.
- `CLK` input, 1: single clock; all logic is rising-edge.
- `RST` input, 1: synchronous, active-high reset.
- `AER_ADDR` input, `IMAGE_SIZE_BITS+2`: event address; `{2'b01, {IMAGE_SIZE_BITS{1'b1}}}` is the frame-start marker (0x1FF at default).
- `AER_REQ` input, 1: single-cycle event strobe; address is sampled in the same cycle.
- `INFERENCE_DONE` input, 1: abort the current frame.
- `AER_BUSY` output, 1: back-pressure; the sender must not strobe while it is high.
- `RANK` output, `[IMAGE_SIZE_BITS-1:0] [0:IMAGE_SIZE-1]`: arrival rank per pixel; 0 means brightest.
- `RANK_VALID` output, `IMAGE_SIZE`: bit i is set once pixel i has been ranked.
- `EVENT_COUNT` output, `IMAGE_SIZE_BITS+1`: number of pixel events ranked in the current frame.
- `FRAME_DONE` output, 1: one-cycle pulse when all `IMAGE_SIZE` pixels have been ranked.
- `ERR_DUPLICATE` output, 1: sticky; a pixel index arrived twice in one frame.
- `ERR_RANGE` output, 1: sticky; non-marker address ≥ `IMAGE_SIZE`.
- `ERR_OVERRUN` output, 1: sticky; `AER_REQ` arrived while `AER_BUSY` was high.

## Operation

- Accept condition: `AER_REQ=1 && AER_BUSY=0`.
  - Every accept, in any state, loads the busy counter with `BUSY_CYCLES`.
  - `AER_REQ` while busy is dropped: no state or table change, and `ERR_OVERRUN` is set.
- FSM states and transitions:
  - IDLE: marker → SYNC1. Non-marker events are ignored and raise no flags.
  - SYNC1: marker → RECEIVE, which clears `RANK_VALID`, `EVENT_COUNT` and all `ERR_*`. Non-marker → IDLE.
  - RECEIVE:
    - In-range index with valid bit clear: `RANK[idx] <= EVENT_COUNT`, set valid bit, increment `EVENT_COUNT`.
    - In-range index with valid bit already set: set `ERR_DUPLICATE`; rank and count unchanged.
    - Out-of-range non-marker: set `ERR_RANGE`; dropped.
    - Marker: → SYNC1 (resynchronisation); the table is kept until the second marker arrives.
    - When the increment makes `EVENT_COUNT` equal `IMAGE_SIZE`: → DONE.
  - DONE: `FRAME_DONE=1` for one cycle, then → IDLE.
- `INFERENCE_DONE` in any state forces IDLE on the next edge.
  - The table, count and error flags are retained.
  - No `FRAME_DONE` pulse is produced.
  - `INFERENCE_DONE` takes priority over a simultaneous accept; that event is still accepted for busy timing but not ranked.
- Arithmetic and widths:
  - `EVENT_COUNT` saturates at `IMAGE_SIZE` and never wraps.
  - `RANK` stores the low `IMAGE_SIZE_BITS` bits of the count, so rank `IMAGE_SIZE-1` is the last pixel ranked.
  - A range check is done before the table is indexed; `AER_ADDR` is never used as an out-of-bounds array index.
- `RANK` contents are not cleared at frame start. Only `RANK_VALID` qualifies them.

## Timing

- Reset values:
  - State = IDLE.
  - `AER_BUSY=0`, `EVENT_COUNT=0`, `RANK_VALID=0`, all `RANK=0`.
  - `FRAME_DONE=0`, all `ERR_*=0`.
- Accept at edge t:
  - Table, valid bit and count updates are visible after edge t+1.
  - `AER_BUSY` is high for cycles t+1 through t+`BUSY_CYCLES` and low at t+`BUSY_CYCLES`+1.
  - The next accept is possible at t+`BUSY_CYCLES`+1.
- Last pixel accepted at t: `EVENT_COUNT=IMAGE_SIZE` at t+1 and state=DONE at t+1, so `FRAME_DONE` is high during cycle t+1 only. State is IDLE at t+2.
- `AER_BUSY` is a pure function of the busy counter; it is never combinational from `AER_REQ`.
- `RST` mid-frame returns every output to its reset value on the next edge, including a busy counter that is still running.

## Test plan

- **Clean frame:** two 0x1FF markers, then indices 5, 0, 255, 1..4, 6..254 with gaps ≥ `BUSY_CYCLES` → `RANK[5]=0`, `RANK[0]=1`, `RANK[255]=2`, `RANK[1]=3`. `FRAME_DONE` pulses exactly once, one cycle after index 254 is accepted. `EVENT_COUNT=256`; no errors.
- **Back-pressure:** strobe on the cycle right after an accept → `ERR_OVERRUN=1` and the event is not ranked. `AER_BUSY` is high for exactly 2 cycles per accept.
- **Preamble handling:**
  - Marker, data 7, marker, marker, 7 → pixel 7 has rank 0 with `EVENT_COUNT=1`; the first 7 is ignored.
  - A single marker followed by data → stays in IDLE; nothing is ranked.
- **Error cases:**
  - Index 9 sent twice → `ERR_DUPLICATE=1`, `RANK[9]` keeps its first rank, count +1 only.
  - Address 0x100 → `ERR_RANGE=1`, count unchanged.
- **Abort:** `INFERENCE_DONE` after 10 events → IDLE next cycle, `EVENT_COUNT=10` retained, no `FRAME_DONE`. A new preamble clears `RANK_VALID` and the errors.
- **Reset mid-frame:** `RST` while busy with `EVENT_COUNT=50` → all outputs return to reset values after one edge and `AER_BUSY=0`.
